if_fetch: RTL and testbench
===========================

# if_fetch

Instruction-fetch stage and IF/ID pipeline register feeding the RV32I decode stage. Owns the fetch PC, issues single-outstanding word requests to instruction memory, buffers returned words in a small queue, and presents `pc_o`/`inst_o`/`is_in_delayslot_o` to decode each cycle. Consumes decode's branch redirect (`branch_flag`, `branch_target_address`, `next_inst_in_delayslot`) and the pipeline hold from the stall controller.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset.
- `clk` input 1, single clock, rising edge.
- `rst` input 1, asynchronous, active-high reset (`RstEnable`).
- `stall_i` input 1, hold IF/ID register (decode load-use stall).
- `branch_flag_i` input 1, decode redirect valid this cycle.
- `branch_target_address_i` input 32, redirect PC.
- `next_inst_in_delayslot_i` input 1, decode's squash flag for the next IF/ID load.
- `mem_req_o` output 1, instruction fetch request.
- `mem_addr_o` output 32, word address of request (bits [1:0] = 0).
- `mem_ack_i` input 1, request accepted and `mem_data_i` valid this cycle.
- `mem_data_i` input 32, fetched instruction word.
- `pc_o` output 32, IF/ID PC to decode.
- `inst_o` output 32, IF/ID instruction to decode.
- `is_in_delayslot_o` output 1, IF/ID squash flag to decode.
- `bubble_o` output 1, registered; IF/ID holds a fetch-starvation NOP.

## Operation
- Queue of DEPTH entries {pc, inst}; DEPTH = 2 with `IF_PREFETCH_EN`, 1 without. Internal `fetch_pc`, `count`, `drop` flag.
- Request: `mem_req_o` = !rst && !drop && count < DEPTH, OR a request already in flight. Once raised, `mem_req_o` and `mem_addr_o` (= `fetch_pc`) stay stable until `mem_ack_i`. Ack may arrive the same cycle as req (zero wait). Never more than one outstanding.
- Ack with `drop`=0 and no redirect this cycle: push {fetch_pc, mem_data_i}; `fetch_pc` += 4 (32-bit wrap at 0xFFFF_FFFC -> 0x0000_0000).
- Ack with `drop`=1: data discarded, `drop` cleared.
- IF/ID load when `stall_i`=0, priority order:
  1. `branch_flag_i`=1 (redirect): queue flushed (count=0); `fetch_pc` <= `branch_target_address_i`; IF/ID <= {pc 0, inst 32'h0000_0013, is_in_delayslot_o <= `next_inst_in_delayslot_i`}; `bubble_o` <= 0. A request in flight and not acked this cycle sets `drop`=1; an ack in the same cycle is discarded. New request issues the next cycle (or after the dropped ack).
  2. count > 0: pop head into `pc_o`/`inst_o`, `is_in_delayslot_o` <= 0, `bubble_o` <= 0.
  3. count = 0: IF/ID <= {pc 0, inst 32'h0000_0013, 0}, `bubble_o` <= 1. Same-cycle ack is pushed, not bypassed.
- `stall_i`=1: IF/ID and `bubble_o` hold; `branch_flag_i` ignored; fetch continues while queue has room.
- Simultaneous push and pop: count unchanged, ordering preserved.
- Redirect target bits [1:0] forced to 0.

## Timing
- Reset values: `pc_o`=0, `inst_o`=0, `is_in_delayslot_o`=0, `bubble_o`=0, `mem_req_o`=0, `mem_addr_o`=`RESET_PC`, count=0, drop=0, `fetch_pc`=`RESET_PC`.
- First request in the first cycle after `rst` falls; zero-wait memory: first word at `inst_o` 2 edges after deassertion.
- Fetch-to-decode latency: ack edge pushes, next non-stalled edge loads IF/ID (1 cycle minimum).
- Throughput, zero-wait memory: 1 instr/cycle with `IF_PREFETCH_EN`; 1 per 2 cycles without.
- Redirect penalty: 1 squashed slot + memory latency + 1.
- `rst` asserted mid-request: all state cleared immediately; pending ack after reset ignored (no request in flight from IF view).

## Configuration
- `IF_PREFETCH_EN` defined: DEPTH=2, request for PC+4 issued while head waits for decode.
- Undefined: DEPTH=1; single-entry buffer, next request only after pop; all other behaviour identical.

## Test plan
- Reset release, zero-wait memory returning addr-derived words: requests 0x0,0x4,0x8…; `inst_o` sequence matches, no bubbles after first (prefetch on), alternate bubbles (prefetch off).
- Memory with 3-cycle ack latency: `bubble_o`=1 with `inst_o`=0x00000013 between words, `mem_addr_o` stable while `mem_req_o` high.
- Redirect to 0x100 while request for 0x10 in flight: next IF/ID `is_in_delayslot_o`=1; 0x10 data dropped; next real `pc_o`=0x100.
- Redirect with same-cycle ack: acked word never appears at `inst_o`; next request address = target.
- `stall_i`=1 for 4 cycles with queue full: IF/ID holds, no request issued, `branch_flag_i` ignored; release resumes in order with no loss.
- `rst` pulse mid-request: outputs return to reset values asynchronously; fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/if_fetch_if.sv
// Instruction-memory request/ack bus between the fetch stage (master) and imem (slave).
interface if_fetch_if;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_data_i;

  modport master (output mem_req_o, mem_addr_o, input mem_ack_i, mem_data_i);
  modport slave  (input mem_req_o, mem_addr_o, output mem_ack_i, mem_data_i);
endinterface

// File: rtl/if_fetch.sv
// RV32I fetch stage + IF/ID register: single-outstanding imem requests, small fetch queue.
// `IF_PREFETCH_EN selects a 2-entry queue (fetch ahead of decode); default is 1 entry.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              branch_flag_i,
  input  logic [31:0]       branch_target_address_i,
  input  logic              next_inst_in_delayslot_i,
  if_fetch_if.master        mem,
  output logic [31:0]       pc_o,
  output logic [31:0]       inst_o,
  output logic              is_in_delayslot_o,
  output logic              bubble_o
);

  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef IF_PREFETCH_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [31:0]             fetch_pc_q, fetch_pc_d;
  logic [31:0]             req_addr_q, req_addr_d;
  logic                    inflight_q, inflight_d;
  logic                    drop_q, drop_d;
  logic [CW-1:0]           count_q, count_d;
  logic [DEPTH-1:0][63:0]  q_q, q_d;  // {pc, inst}, head at index 0
  logic [31:0]             pc_q, pc_d, inst_q, inst_d;
  logic                    dly_q, dly_d, bubble_q, bubble_d;

  logic                    req, ack, redirect, push, pop;
  logic [31:0]             cur_addr;
  logic [CW-1:0]           slot;

  always_comb begin
    // An accepted request holds its original address even if a redirect moves fetch_pc.
    req      = inflight_q | (!rst & !drop_q & (count_q < FULL));
    cur_addr = inflight_q ? req_addr_q : fetch_pc_q;
    ack      = req & mem.mem_ack_i;
    redirect = branch_flag_i & !stall_i;
    push     = ack & !drop_q & !redirect;
    pop      = !stall_i & !redirect & (count_q != '0);

    inflight_d = req & !ack;
    req_addr_d = cur_addr;
    drop_d     = redirect ? (req & !ack) : (drop_q & !ack);

    fetch_pc_d = fetch_pc_q;
    if (redirect)  fetch_pc_d = branch_target_address_i & ~32'h3;
    else if (push) fetch_pc_d = fetch_pc_q + 32'd4;

    q_d     = q_q;
    count_d = count_q;
    slot    = count_q;
    if (redirect) begin
      count_d = '0;
    end else begin
      if (pop) begin
        q_d  = q_q >> 64;
        slot = count_q - 1'b1;
      end
      if (push)
        for (int i = 0; i < DEPTH; i++)
          if (CW'(i) == slot) q_d[i] = {cur_addr, mem.mem_data_i};
      count_d = count_q + CW'(push) - CW'(pop);
    end

    pc_d     = pc_q;
    inst_d   = inst_q;
    dly_d    = dly_q;
    bubble_d = bubble_q;
    if (!stall_i) begin
      if (redirect) begin
        pc_d     = '0;
        inst_d   = NOP;
        dly_d    = next_inst_in_delayslot_i;
        bubble_d = 1'b0;
      end else if (count_q != '0) begin
        pc_d     = q_q[0][63:32];
        inst_d   = q_q[0][31:0];
        dly_d    = 1'b0;
        bubble_d = 1'b0;
      end else begin
        pc_d     = '0;
        inst_d   = NOP;
        dly_d    = 1'b0;
        bubble_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
      inflight_q <= 1'b0;
      drop_q     <= 1'b0;
      count_q    <= '0;
      q_q        <= '0;
      pc_q       <= '0;
      inst_q     <= '0;
      dly_q      <= 1'b0;
      bubble_q   <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      count_q    <= count_d;
      q_q        <= q_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      dly_q      <= dly_d;
      bubble_q   <= bubble_d;
    end
  end

  assign mem.mem_req_o     = req;
  assign mem.mem_addr_o    = cur_addr;
  assign pc_o              = pc_q;
  assign inst_o            = inst_q;
  assign is_in_delayslot_o = dly_q;
  assign bubble_o          = bubble_q;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch with a latency-programmable instruction memory model.
module tb_if_fetch;
  logic        clk, rst, stall_i, branch_flag_i, next_inst_in_delayslot_i;
  logic [31:0] branch_target_address_i, pc_o, inst_o;
  logic        is_in_delayslot_o, bubble_o;
  logic        mem_en;
  int          lat, wcnt;
  int          n_cmp = 0, n_bad = 0;

  if_fetch_if mem_bus();

  if_fetch dut (
    .clk                      (clk),
    .rst                      (rst),
    .stall_i                  (stall_i),
    .branch_flag_i            (branch_flag_i),
    .branch_target_address_i  (branch_target_address_i),
    .next_inst_in_delayslot_i (next_inst_in_delayslot_i),
    .mem                      (mem_bus),
    .pc_o                     (pc_o),
    .inst_o                   (inst_o),
    .is_in_delayslot_o        (is_in_delayslot_o),
    .bubble_o                 (bubble_o)
  );

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {4'hC, a[27:0]};
  endfunction

  // Memory: acks after `lat` waiting cycles, data derived from address.
  assign mem_bus.mem_ack_i  = mem_en && mem_bus.mem_req_o && (wcnt >= lat);
  assign mem_bus.mem_data_i = word_of(mem_bus.mem_addr_o);

  always @(posedge clk or posedge rst) begin
    if (rst) wcnt <= 0;
    else if (!mem_bus.mem_req_o || mem_bus.mem_ack_i) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; branch_flag_i = 1'b0; stall_i = 1'b0; next_inst_in_delayslot_i = 1'b0;
    branch_target_address_i = '0; mem_en = 1'b1; lat = 0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    step();
    n_cmp++; if (pc_o !== 32'h0) begin n_bad++; $display("FAIL reset_pc: got %h want %h", pc_o, 32'h0); end
    n_cmp++; if (inst_o !== 32'h0) begin n_bad++; $display("FAIL reset_inst: got %h want %h", inst_o, 32'h0); end
    n_cmp++; if (is_in_delayslot_o !== 1'b0) begin n_bad++; $display("FAIL reset_dly: got %b want 0", is_in_delayslot_o); end
    n_cmp++; if (bubble_o !== 1'b0) begin n_bad++; $display("FAIL reset_bubble: got %b want 0", bubble_o); end
    n_cmp++; if (mem_bus.mem_req_o !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b want 0", mem_bus.mem_req_o); end
    n_cmp++; if (mem_bus.mem_addr_o !== 32'h0) begin n_bad++; $display("FAIL reset_addr: got %h want %h", mem_bus.mem_addr_o, 32'h0); end
  endtask

  task automatic test_zero_wait();
    logic        exp_b;
    logic [31:0] exp_pc;
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      step();
`ifdef IF_PREFETCH_EN
      exp_b  = (k == 1);
      exp_pc = 32'(4 * (k - 2));
`else
      exp_b  = (k % 2) == 1;
      exp_pc = 32'(4 * (k / 2 - 1));
`endif
      n_cmp++; if (bubble_o !== exp_b) begin n_bad++; $display("FAIL zw_bubble edge %0d: got %b want %b", k, bubble_o, exp_b); end
      if (exp_b) begin
        n_cmp++; if (inst_o !== 32'h13) begin n_bad++; $display("FAIL zw_nop edge %0d: got %h want %h", k, inst_o, 32'h13); end
      end else begin
        n_cmp++; if (pc_o !== exp_pc || inst_o !== word_of(exp_pc))
          begin n_bad++; $display("FAIL zw_word edge %0d: got pc %h inst %h want pc %h inst %h", k, pc_o, inst_o, exp_pc, word_of(exp_pc)); end
      end
    end
  endtask

  task automatic test_latency();
    do_reset();
    lat = 3;
    for (int k = 1; k <= 3; k++) begin
      step();
      n_cmp++; if (mem_bus.mem_req_o !== 1'b1) begin n_bad++; $display("FAIL lat_req edge %0d: got %b want 1", k, mem_bus.mem_req_o); end
      n_cmp++; if (mem_bus.mem_addr_o !== 32'h0) begin n_bad++; $display("FAIL lat_addr edge %0d: got %h want 0", k, mem_bus.mem_addr_o); end
      n_cmp++; if (bubble_o !== 1'b1 || inst_o !== 32'h13) begin n_bad++; $display("FAIL lat_bubble edge %0d: got %b/%h want 1/%h", k, bubble_o, inst_o, 32'h13); end
    end
    step();
    n_cmp++; if (bubble_o !== 1'b1 || inst_o !== 32'h13) begin n_bad++; $display("FAIL lat_nobypass: got %b/%h want 1/%h", bubble_o, inst_o, 32'h13); end
    step();
    n_cmp++; if (bubble_o !== 1'b0 || pc_o !== 32'h0 || inst_o !== word_of(32'h0))
      begin n_bad++; $display("FAIL lat_word0: got %b/%h/%h want 0/%h/%h", bubble_o, pc_o, inst_o, 32'h0, word_of(32'h0)); end
    step();
    n_cmp++; if (bubble_o !== 1'b1) begin n_bad++; $display("FAIL lat_gap: got %b want 1", bubble_o); end
  endtask

  task automatic test_redirect_inflight();
    do_reset();
    mem_en = 1'b0; branch_flag_i = 1'b1; branch_target_address_i = 32'h10;
    step();
    branch_flag_i = 1'b0;
    n_cmp++; if (bubble_o !== 1'b0 || inst_o !== 32'h13 || is_in_delayslot_o !== 1'b0)
      begin n_bad++; $display("FAIL rd_slot0: got %b/%h/%b want 0/%h/0", bubble_o, inst_o, is_in_delayslot_o, 32'h13); end
    step();
    mem_en = 1'b1;
    step();
    mem_en = 1'b0;
    n_cmp++; if (mem_bus.mem_req_o !== 1'b1 || mem_bus.mem_addr_o !== 32'h10)
      begin n_bad++; $display("FAIL rd_req10: got %b/%h want 1/%h", mem_bus.mem_req_o, mem_bus.mem_addr_o, 32'h10); end
    step();
    branch_flag_i = 1'b1; branch_target_address_i = 32'h103; next_inst_in_delayslot_i = 1'b1;
    step();
    branch_flag_i = 1'b0; next_inst_in_delayslot_i = 1'b0;
    n_cmp++; if (is_in_delayslot_o !== 1'b1 || inst_o !== 32'h13 || pc_o !== 32'h0 || bubble_o !== 1'b0)
      begin n_bad++; $display("FAIL rd_squash: got %b/%h/%h/%b want 1/%h/0/0", is_in_delayslot_o, inst_o, pc_o, bubble_o, 32'h13); end
    n_cmp++; if (mem_bus.mem_req_o !== 1'b1 || mem_bus.mem_addr_o !== 32'h10)
      begin n_bad++; $display("FAIL rd_hold10: got %b/%h want 1/%h", mem_bus.mem_req_o, mem_bus.mem_addr_o, 32'h10); end
    mem_en = 1'b1;
    step();
    n_cmp++; if (mem_bus.mem_req_o !== 1'b1 || mem_bus.mem_addr_o !== 32'h100)
      begin n_bad++; $display("FAIL rd_req100: got %b/%h want 1/%h", mem_bus.mem_req_o, mem_bus.mem_addr_o, 32'h100); end
    step();
    n_cmp++; if (bubble_o !== 1'b1 || inst_o !== 32'h13) begin n_bad++; $display("FAIL rd_gap: got %b/%h want 1/%h", bubble_o, inst_o, 32'h13); end
    step();
    n_cmp++; if (pc_o !== 32'h100 || inst_o !== word_of(32'h100) || is_in_delayslot_o !== 1'b0)
      begin n_bad++; $display("FAIL rd_target: got %h/%h/%b want %h/%h/0", pc_o, inst_o, is_in_delayslot_o, 32'h100, word_of(32'h100)); end
  endtask

  task automatic test_redirect_same_ack();
    do_reset();
    branch_flag_i = 1'b1; branch_target_address_i = 32'h200;
    step();
    branch_flag_i = 1'b0;
    n_cmp++; if (mem_bus.mem_req_o !== 1'b1 || mem_bus.mem_addr_o !== 32'h200)
      begin n_bad++; $display("FAIL sa_req: got %b/%h want 1/%h", mem_bus.mem_req_o, mem_bus.mem_addr_o, 32'h200); end
    step();
    n_cmp++; if (bubble_o !== 1'b1 || inst_o !== 32'h13) begin n_bad++; $display("FAIL sa_gap: got %b/%h want 1/%h", bubble_o, inst_o, 32'h13); end
    step();
    n_cmp++; if (pc_o !== 32'h200 || inst_o !== word_of(32'h200))
      begin n_bad++; $display("FAIL sa_target: got %h/%h want %h/%h", pc_o, inst_o, 32'h200, word_of(32'h200)); end
  endtask

  task automatic test_stall();
    int          got;
    logic [31:0] exp_pc;
    do_reset();
    stall_i = 1'b1; branch_flag_i = 1'b1; branch_target_address_i = 32'h300;
    step();
    for (int k = 2; k <= 5; k++) begin
      step();
      n_cmp++; if (mem_bus.mem_req_o !== 1'b0) begin n_bad++; $display("FAIL st_req edge %0d: got %b want 0", k, mem_bus.mem_req_o); end
      n_cmp++; if (inst_o !== 32'h0 || pc_o !== 32'h0 || bubble_o !== 1'b0)
        begin n_bad++; $display("FAIL st_hold edge %0d: got %h/%h/%b want 0/0/0", k, pc_o, inst_o, bubble_o); end
    end
    stall_i = 1'b0; branch_flag_i = 1'b0;
    got = 0; exp_pc = 32'h0;
    for (int c = 0; c < 12 && got < 3; c++) begin
      step();
      if (inst_o[31:28] == 4'hC) begin
        n_cmp++; if (pc_o !== exp_pc || inst_o !== word_of(exp_pc))
          begin n_bad++; $display("FAIL st_order: got %h/%h want %h/%h", pc_o, inst_o, exp_pc, word_of(exp_pc)); end
        exp_pc += 32'd4; got++;
      end
    end
    n_cmp++; if (got != 3) begin n_bad++; $display("FAIL st_count: got %0d want 3", got); end
  endtask

  task automatic test_wrap();
    int          got;
    logic [31:0] exp_pc;
    do_reset();
    branch_flag_i = 1'b1; branch_target_address_i = 32'hFFFF_FFFC;
    step();
    branch_flag_i = 1'b0;
    got = 0; exp_pc = 32'hFFFF_FFFC;
    for (int c = 0; c < 12 && got < 3; c++) begin
      step();
      if (inst_o[31:28] == 4'hC) begin
        n_cmp++; if (pc_o !== exp_pc || inst_o !== word_of(exp_pc))
          begin n_bad++; $display("FAIL wrap_seq: got %h/%h want %h/%h", pc_o, inst_o, exp_pc, word_of(exp_pc)); end
        exp_pc += 32'd4; got++;
      end
    end
    n_cmp++; if (got != 3) begin n_bad++; $display("FAIL wrap_count: got %0d want 3", got); end
  endtask

  task automatic test_rst_mid();
    int          got;
    logic        found;
    logic [31:0] exp_pc;
    do_reset();
    found = 1'b0;
    for (int c = 0; c < 12 && !found; c++) begin
      step();
      if (pc_o == 32'h8 && inst_o == word_of(32'h8)) found = 1'b1;
    end
    n_cmp++; if (found !== 1'b1) begin n_bad++; $display("FAIL rm_reach8: got %b want 1", found); end
    mem_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (pc_o !== 32'h0 || inst_o !== 32'h0 || bubble_o !== 1'b0 || is_in_delayslot_o !== 1'b0)
      begin n_bad++; $display("FAIL rm_async_ifid: got %h/%h/%b/%b want 0/0/0/0", pc_o, inst_o, bubble_o, is_in_delayslot_o); end
    n_cmp++; if (mem_bus.mem_req_o !== 1'b0 || mem_bus.mem_addr_o !== 32'h0)
      begin n_bad++; $display("FAIL rm_async_bus: got %b/%h want 0/0", mem_bus.mem_req_o, mem_bus.mem_addr_o); end
    step();
    rst = 1'b0; mem_en = 1'b1;
    got = 0; exp_pc = 32'h0;
    for (int c = 0; c < 12 && got < 2; c++) begin
      step();
      if (inst_o[31:28] == 4'hC) begin
        n_cmp++; if (pc_o !== exp_pc || inst_o !== word_of(exp_pc))
          begin n_bad++; $display("FAIL rm_restart: got %h/%h want %h/%h", pc_o, inst_o, exp_pc, word_of(exp_pc)); end
        exp_pc += 32'd4; got++;
      end
    end
    n_cmp++; if (got != 2) begin n_bad++; $display("FAIL rm_count: got %0d want 2", got); end
  endtask

  initial begin
    rst = 1'b1; stall_i = 1'b0; branch_flag_i = 1'b0; next_inst_in_delayslot_i = 1'b0;
    branch_target_address_i = '0; mem_en = 1'b1; lat = 0;
    test_reset();
    test_zero_wait();
    test_latency();
    test_redirect_inflight();
    test_redirect_same_ack();
    test_stall();
    test_wrap();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
